// File: rtl/uart_cpld_responder_if.sv
// ---------------------------------------------------------------------------
// uart_cpld_responder_if
// Strobe/status handshake between the CPU side and the UART responder.
//   rdn        : read strobe, active low (CPU -> responder)
//   wrn        : write strobe, active low (CPU -> responder)
//   tbre       : transmit holding register empty (responder -> CPU)
//   tsre       : transmit shift register empty, line idle (responder -> CPU)
//   data_ready : receive holding register full (responder -> CPU)
// The shared data byte stays a plain inout on the responder so it can sit
// directly on the low byte of the base-RAM data bus.
// ---------------------------------------------------------------------------
interface uart_cpld_responder_if;
    logic rdn;
    logic wrn;
    logic tbre;
    logic tsre;
    logic data_ready;

    modport master (
        output rdn,
        output wrn,
        input  tbre,
        input  tsre,
        input  data_ready
    );

    modport slave (
        input  rdn,
        input  wrn,
        output tbre,
        output tsre,
        output data_ready
    );
endinterface

// File: rtl/uart_cpld_responder.sv
// ---------------------------------------------------------------------------
// uart_cpld_responder
// Stands in for the external UART CPLD: bytes written with wrn strobes are
// sent on txd as 8N1 frames, and frames arriving on rxd land in a one-byte
// holding register that is driven onto bus_data while rdn is low.
//
// Ports:
//   clk      : block clock, at least 4x the CPU clock
//   rst_n    : asynchronous active-low reset
//   bus      : strobe/status interface (slave modport)
//   bus_data : shared data bus bits [7:0]; driven only while raw rdn is low
//   txd      : serial transmit, idle high
//   rxd      : serial receive, asynchronous
//
// Parameters:
//   CLKS_PER_BIT : clk cycles per serial bit (4..65535)
//   CNT_W        : bit-period counter width, must hold CLKS_PER_BIT-1
//
// Build option UART_LOOPBACK_EN: receiver listens to the internal transmit
// bit instead of rxd, and the external txd pin is held high.
// ---------------------------------------------------------------------------
module uart_cpld_responder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_cpld_responder_if.slave  bus,
    inout  wire  [7:0]            bus_data,
    output logic                  txd,
    input  logic                  rxd
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value
    logic [2:0]       rdn_sync_q, wrn_sync_q, rxd_sync_q;
    logic             rx_src_s;
    logic             rdn_rise_s, wrn_fall_s, wrn_rise_s, rxd_fall_s, rxd_s;

    tx_state_t        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_idx_q, tx_idx_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic [7:0]       tx_hold_q, tx_hold_d;
    logic [7:0]       wr_byte_q, wr_byte_d;
    logic             tbre_q, tbre_d, tsre_q, tsre_d, txd_q, txd_d;
    logic             take_s;

    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_idx_q, rx_idx_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_hold_q, rx_hold_d;
    logic             data_ready_q, data_ready_d;

`ifdef UART_LOOPBACK_EN
    assign rx_src_s = txd_q;
    assign txd      = 1'b1;
`else
    assign rx_src_s = rxd;
    assign txd      = txd_q;
`endif

    assign rdn_rise_s = ~rdn_sync_q[2] &  rdn_sync_q[1];
    assign wrn_fall_s =  wrn_sync_q[2] & ~wrn_sync_q[1];
    assign wrn_rise_s = ~wrn_sync_q[2] &  wrn_sync_q[1];
    assign rxd_fall_s =  rxd_sync_q[2] & ~rxd_sync_q[1];
    assign rxd_s      =  rxd_sync_q[1];

    // Output enable follows the raw strobe so data is valid within the CPU half-cycle
    assign bus_data = bus.rdn ? 8'hzz : rx_hold_q;

    assign bus.tbre       = tbre_q;
    assign bus.tsre       = tsre_q;
    assign bus.data_ready = data_ready_q;

    // Write capture and transmit FSM next-state logic
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_hold_d  = tx_hold_q;
        wr_byte_d  = wr_byte_q;
        tbre_d     = tbre_q;
        tsre_d     = tsre_q;
        take_s     = 1'b0;

        if (wrn_fall_s) begin
            wr_byte_d = bus_data;
        end else begin
            wr_byte_d = wr_byte_q;
        end

        // tbre low means tx_hold holds a byte waiting for the shifter
        case (tx_state_q)
            TX_IDLE: begin
                if (!tbre_q) begin
                    take_s     = 1'b1;
                    tx_state_d = TX_START;
                    tx_cnt_d   = CNT_ZERO;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = CNT_ZERO;
                    tx_idx_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (!tbre_q) begin
                        // pending byte: next start bit follows with no idle gap
                        take_s     = 1'b1;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tsre_d     = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
            end
        endcase

        if (take_s) begin
            tx_shift_d = tx_hold_q;
            tbre_d     = 1'b1;
            tsre_d     = 1'b0;
        end else begin
            tbre_d = tbre_d;
        end

        // A transfer in this cycle empties tx_hold, so a coincident write still fits
        if (wrn_rise_s && (tbre_q || take_s)) begin
            tx_hold_d = wr_byte_q;
            tbre_d    = 1'b0;
        end else begin
            tx_hold_d = tx_hold_d;
        end

        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_shift_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    // Receive FSM next-state logic and holding-register update
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_idx_d     = rx_idx_q;
        rx_shift_d   = rx_shift_q;
        rx_hold_d    = rx_hold_q;
        data_ready_d = data_ready_q;

        if (rdn_rise_s) begin
            data_ready_d = 1'b0;
        end else begin
            data_ready_d = data_ready_q;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_fall_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = CNT_ZERO;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d = CNT_ZERO;
                    rx_idx_d = 3'd0;
                    if (rxd_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = RX_IDLE;
                    // a read completing in this very cycle frees the holding register
                    if (rxd_s && (!data_ready_q || rdn_rise_s)) begin
                        rx_hold_d    = rx_shift_q;
                        data_ready_d = 1'b1;
                    end else begin
                        rx_hold_d = rx_hold_q;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // State, counter, data and synchronizer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdn_sync_q   <= 3'b111;
            wrn_sync_q   <= 3'b111;
            rxd_sync_q   <= 3'b111;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= CNT_ZERO;
            tx_idx_q     <= 3'd0;
            tx_shift_q   <= 8'h00;
            tx_hold_q    <= 8'h00;
            wr_byte_q    <= 8'h00;
            tbre_q       <= 1'b1;
            tsre_q       <= 1'b1;
            txd_q        <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= CNT_ZERO;
            rx_idx_q     <= 3'd0;
            rx_shift_q   <= 8'h00;
            rx_hold_q    <= 8'h00;
            data_ready_q <= 1'b0;
        end else begin
            rdn_sync_q   <= {rdn_sync_q[1:0], bus.rdn};
            wrn_sync_q   <= {wrn_sync_q[1:0], bus.wrn};
            rxd_sync_q   <= {rxd_sync_q[1:0], rx_src_s};
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_shift_q   <= tx_shift_d;
            tx_hold_q    <= tx_hold_d;
            wr_byte_q    <= wr_byte_d;
            tbre_q       <= tbre_d;
            tsre_q       <= tsre_d;
            txd_q        <= txd_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_shift_q   <= rx_shift_d;
            rx_hold_q    <= rx_hold_d;
            data_ready_q <= data_ready_d;
        end
    end

endmodule

// File: tb/tb_uart_cpld_responder.sv
// ---------------------------------------------------------------------------
// tb_uart_cpld_responder
// Directed bench for uart_cpld_responder with CLKS_PER_BIT=4. Outputs are
// sampled on the falling clock edge; inputs change on the falling edge.
// Building with UART_LOOPBACK_EN selects the loopback scenario.
// ---------------------------------------------------------------------------
module tb_uart_cpld_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd = 1'b1;
    logic       txd;
    logic [7:0] tb_bus_val = 8'h00;
    logic       tb_bus_oe = 1'b0;
    wire  [7:0] bus_data;
    int         checks = 0;
    int         errors = 0;

    uart_cpld_responder_if bus_if ();

    assign bus_data = tb_bus_oe ? tb_bus_val : 8'hzz;

    uart_cpld_responder #(.CLKS_PER_BIT(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .bus_data (bus_data),
        .txd      (txd),
        .rxd      (rxd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        tb_bus_val = b;
        tb_bus_oe  = 1'b1;
        bus_if.wrn = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.wrn = 1'b1;
        tb_bus_oe  = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Waits for a start bit, then samples nbits bit-centres of txd
    task automatic capture(input int nbits, output logic [31:0] bits);
        int g = 0;
        bits = 32'h0;
        while (txd !== 1'b0 && g < 80) begin
            @(negedge clk);
            g++;
        end
        check("tx_start_seen", {31'd0, txd}, 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bits[i] = txd;
            if (i < nbits - 1) repeat (4) @(negedge clk);
        end
    endtask

    task automatic count_txd_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (txd === 1'b0) lows++;
        end
    endtask

    task automatic probe_released(input string tag);
        tb_bus_val = 8'h96;
        tb_bus_oe  = 1'b1;
        #1;
        check(tag, {24'd0, bus_data}, 32'h96);
        tb_bus_oe  = 1'b0;
    endtask

    initial begin
        logic [31:0] bits;
        int          n_tbre;
        int          n_tsre;
        int          lows;
        int          g;

        bus_if.rdn = 1'b1;
        bus_if.wrn = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tbre", {31'd0, bus_if.tbre}, 32'd1);
        check("rst_tsre", {31'd0, bus_if.tsre}, 32'd1);
        check("rst_data_ready", {31'd0, bus_if.data_ready}, 32'd0);
        check("rst_txd", {31'd0, txd}, 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef UART_LOOPBACK_EN
        fork
            write_byte(8'h5A);
            count_txd_low(80, lows);
        join
        g = 0;
        while (bus_if.data_ready !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check("lb_data_ready", {31'd0, bus_if.data_ready}, 32'd1);
        check("lb_txd_held_high", lows, 32'd0);
        bus_if.rdn = 1'b0;
        #1;
        check("lb_rx_hold", {24'd0, bus_data}, 32'h5A);
        bus_if.rdn = 1'b1;
        repeat (6) @(negedge clk);
        check("lb_read_clears", {31'd0, bus_if.data_ready}, 32'd0);
        probe_released("lb_bus_released");
`else
        // Single write 0xA5: tbre low one cycle, 40-cycle frame
        n_tbre = 0;
        n_tsre = 0;
        fork
            write_byte(8'hA5);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (bus_if.tbre === 1'b0) n_tbre++;
                end
            end
            begin
                g = 0;
                while (bus_if.tsre !== 1'b0 && g < 60) begin
                    @(negedge clk);
                    g++;
                end
                while (bus_if.tsre === 1'b0 && n_tsre < 100) begin
                    n_tsre++;
                    @(negedge clk);
                end
            end
            capture(10, bits);
        join
        check("a5_frame", bits, 32'h34A);
        check("a5_tbre_low_cycles", n_tbre, 32'd1);
        check("a5_tsre_low_cycles", n_tsre, 32'd40);
        check("a5_txd_idle", {31'd0, txd}, 32'd1);
        check("a5_tsre_after", {31'd0, bus_if.tsre}, 32'd1);

        // Back-to-back 0x11, 0x22; 0x33 arrives while tbre=0 and is dropped
        fork
            capture(20, bits);
            begin
                write_byte(8'h11);
                write_byte(8'h22);
                write_byte(8'h33);
                check("b2b_tbre_full", {31'd0, bus_if.tbre}, 32'd0);
            end
        join
        check("b2b_frames", bits, 32'h91222);
        count_txd_low(60, lows);
        check("b2b_no_third_frame", lows, 32'd0);
        check("b2b_tsre_after", {31'd0, bus_if.tsre}, 32'd1);

        // Receive 0x3C and read it back
        send_rx(8'h3C, 1'b1);
        check("rx_data_ready", {31'd0, bus_if.data_ready}, 32'd1);
        probe_released("rx_bus_released");
        bus_if.rdn = 1'b0;
        #1;
        check("rx_bus_value", {24'd0, bus_data}, 32'h3C);
        repeat (3) @(negedge clk);
        check("rx_ready_during_read", {31'd0, bus_if.data_ready}, 32'd1);
        bus_if.rdn = 1'b1;
        repeat (4) @(negedge clk);
        check("rx_ready_cleared", {31'd0, bus_if.data_ready}, 32'd0);
        probe_released("rx_bus_released_after");

        // Framing error: stop bit 0
        send_rx(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        check("frame_err_no_ready", {31'd0, bus_if.data_ready}, 32'd0);

        // Overrun: second frame must not replace the first
        send_rx(8'h01, 1'b1);
        send_rx(8'h02, 1'b1);
        check("ovr_data_ready", {31'd0, bus_if.data_ready}, 32'd1);
        bus_if.rdn = 1'b0;
        #1;
        check("ovr_kept_first", {24'd0, bus_data}, 32'h01);
        repeat (3) @(negedge clk);
        bus_if.rdn = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_read_clears", {31'd0, bus_if.data_ready}, 32'd0);

        // Reset in the middle of a transmit frame with a byte held
        send_rx(8'h7E, 1'b1);
        check("pre_rst_ready", {31'd0, bus_if.data_ready}, 32'd1);
        write_byte(8'h0F);
        check("pre_rst_txd_start", {31'd0, txd}, 32'd0);
        check("pre_rst_tsre", {31'd0, bus_if.tsre}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", {31'd0, txd}, 32'd1);
        check("mid_rst_tbre", {31'd0, bus_if.tbre}, 32'd1);
        check("mid_rst_tsre", {31'd0, bus_if.tsre}, 32'd1);
        check("mid_rst_data_ready", {31'd0, bus_if.data_ready}, 32'd0);
        probe_released("mid_rst_bus_released");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_txd_low(60, lows);
        check("post_rst_no_frame", lows, 32'd0);
        check("post_rst_tsre", {31'd0, bus_if.tsre}, 32'd1);
        bus_if.rdn = 1'b0;
        #1;
        check("post_rst_rx_hold", {24'd0, bus_data}, 32'h00);
        bus_if.rdn = 1'b1;
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
